// File: rtl/spin_readout_pkg.sv
// Shared state encoding and default timing constants for the spin readout block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spin_readout_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_WINDOW_CYCLES = 256;

endpackage

// File: rtl/spin_readout_phase_sync.sv
// Two-flop synchronizer bringing one free-running oscillator bit into the clk domain.
// Latency: output lags the input by 2 clk edges.
// Backpressure: none; samples every cycle.
module phase_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spin_readout.sv
// Resets/settles the oscillator core, counts per-oscillator phase mismatches vs osc 0, reports spins.
// Latency: valid rises SETTLE_CYCLES + WINDOW_CYCLES + 1 edges after start is sampled (start edge counted).
// Backpressure: result held with valid=1 until ready; start is only accepted in IDLE.
module spin_readout
  import spin_readout_pkg::*;
#(
  parameter int N             = 3,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] osc_in,
  output logic         core_rstn,
  output logic         busy,
  output logic [N-1:0] spins,
  output logic         valid,
  input  logic         ready
);

  localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  // One counter times both the settle and measure phases, so it must fit the longer of the two.
  localparam int CYC_W = (SET_W > CNT_W) ? SET_W : CNT_W;

  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] WINDOW_LAST = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W:0]   WINDOW_CMP  = (CNT_W + 1)'(WINDOW_CYCLES);

  state_t           state;
  logic [CYC_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] mm     [N];
  logic [CNT_W-1:0] mm_fin [N];
  logic [N-1:0]     s;
  logic [N-1:0]     mis;
  logic [N-1:0]     spins_nxt;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_sync
      phase_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (osc_in[g]),
        .q    (s[g])
      );
    end
  endgenerate

  // Bit 0 compares oscillator 0 against itself, so it is always 0.
  assign mis = s ^ {N{s[0]}};

  // Counts including the current sample, and the majority decision taken on the final window edge.
  always_comb begin
    spins_nxt = '0;
    for (int i = 0; i < N; i++) begin
      mm_fin[i] = mm[i] + CNT_W'(mis[i]);
    end
    for (int i = 1; i < N; i++) begin
      // Strictly more than half the window mismatched; an exact tie reads as in-phase.
      spins_nxt[i] = ({mm_fin[i], 1'b0} > WINDOW_CMP);
    end
  end

  // Sequencer: settle the core, measure for the window, then hold the result until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      core_rstn <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      spins     <= '0;
      for (int i = 0; i < N; i++) mm[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SETTLE;
            cyc_cnt   <= '0;
            core_rstn <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SETTLE: begin
          if (cyc_cnt == SETTLE_LAST) begin
            state   <= MEASURE;
            cyc_cnt <= '0;
            for (int i = 0; i < N; i++) mm[i] <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        MEASURE: begin
          for (int i = 1; i < N; i++) mm[i] <= mm_fin[i];
          if (cyc_cnt == WINDOW_LAST) begin
            state     <= DONE;
            spins     <= spins_nxt;
            core_rstn <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DONE: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_readout.sv
// Directed sequence with randomized oscillator patterns, checked against a history-based mismatch model.
module tb_spin_readout;

  localparam int N  = 4;
  localparam int ST = 8;
  localparam int WN = 16;
  // Edge numbering: edge 1 samples start; valid appears after edge ST+WN+1.
  // Measurement edges are ST+2 .. ST+WN+1 and, with the 2-flop lag, see osc values driven at edges ST .. ST+WN-1.
  localparam int LAT = ST + WN + 1;

  logic         clk, rstn, start, ready;
  logic [N-1:0] osc_in;
  logic         core_rstn, busy, valid;
  logic [N-1:0] spins;

  int total  = 0;
  int passed = 0;
  logic [N-1:0] hist [0:63];

  spin_readout #(.N(N), .SETTLE_CYCLES(ST), .WINDOW_CYCLES(WN)) dut (
    .clk(clk), .rstn(rstn), .start(start), .osc_in(osc_in),
    .core_rstn(core_rstn), .busy(busy), .spins(spins), .valid(valid), .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Oscillator pattern for edge n of a run.
  function automatic logic [N-1:0] pat(input int mode, input int n);
    logic [31:0] r;
    logic b, m1, m3;
    int k;
    r = $urandom;
    b = ((n / 2) % 2) == 1;
    k = n - ST;
    case (mode)
      0: pat = {~b, b, ~b, b};
      1: begin
        if (k >= 0 && k < WN) begin
          m1 = (k % 2) == 0;   // 8 mismatches out of 16
          m3 = (k < 9);        // 9 mismatches out of 16
        end else begin
          m1 = r[1];
          m3 = r[3];
        end
        pat = {r[0] ^ m3, r[2], r[0] ^ m1, r[0]};
      end
      2: pat = r[N-1:0];
      default: pat = {~b, ~b, ~b, b};
    endcase
  endfunction

  // Majority of disagreements with oscillator 0 over the window samples recorded in hist.
  function automatic logic [N-1:0] model_spins();
    logic [N-1:0] res;
    int mm;
    res = '0;
    for (int i = 1; i < N; i++) begin
      mm = 0;
      for (int n = ST; n < ST + WN; n++) mm += (hist[n][i] != hist[n][0]) ? 1 : 0;
      res[i] = (2 * mm > WN);
    end
    return res;
  endfunction

  // Called at a negedge; returns just after the edge on which valid rose (or after the cycle bound).
  task automatic do_run(input int mode, input string tag);
    int lat;
    logic [N-1:0] exp_s;
    lat = 0;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) start = 1'b0;
      hist[n] = pat(mode, n);
      osc_in  = hist[n];
      @(posedge clk); #1;
      if (n == 1) begin
        chk({tag, "_core_rstn_up"}, core_rstn, 1);
        chk({tag, "_busy_up"}, busy, 1);
      end
      if (valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_s = model_spins();
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_spins"}, spins, exp_s);
    chk({tag, "_core_rstn_down"}, core_rstn, 0);
    chk({tag, "_busy_down"}, busy, 0);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, valid, 0);
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] held;
    rstn = 1'b0; start = 1'b0; ready = 1'b0; osc_in = '0;

    // Reset then idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_outs", {core_rstn, busy, valid, spins}, 0);
    end
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      osc_in = $urandom;
      chk("idle_outs", {core_rstn, busy, valid, spins}, 0);
    end

    // Basic readout with clk/4 square waves.
    do_run(0, "basic");
    chk("basic_const", spins, 4'b1010);
    handshake("basic");

    // Tie vs threshold.
    do_run(1, "tie");
    chk("tie_spin1", spins[1], 0);
    chk("tie_spin3", spins[3], 1);
    handshake("tie");

    // Random pattern then backpressure with a stray start in DONE.
    do_run(2, "rand");
    held = spins;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ready = 1'b0;
      osc_in = $urandom;
      start = (c == 4);
      @(posedge clk); #1;
      chk("bp_valid", valid, 1);
      chk("bp_spins", spins, held);
      chk("bp_busy", busy, 0);
    end
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", valid, 0);
    chk("bp_idle", {busy, core_rstn}, 0);
    chk("bp_spins_kept", spins, held);
    @(negedge clk);
    ready = 1'b0;

    // Back-to-back: start on the first IDLE cycle, all anti-phase.
    do_run(3, "b2b");
    chk("b2b_const", spins, 4'b1110);
    handshake("b2b");

    // Reset five cycles into MEASURE.
    start = 1'b1;
    for (int e = 1; e <= ST + 1 + 5; e++) begin
      osc_in = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
    end
    chk("mid_busy", busy, 1);
    chk("mid_spins_kept", spins, 4'b1110);
    chk("mid_valid", valid, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_outs", {core_rstn, busy, valid, spins}, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mid_rst_hold", {core_rstn, busy, valid}, 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    do_run(2, "after_rst");
    handshake("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
